// File: rtl/macc_stage.sv
// ============================================================================
//  Module   : macc_stage
//  Purpose  : Memory-access pipeline stage. Runs one outstanding load/store on
//             a req/gnt/rvalid bus with byte-lane steering and load extension,
//             and registers the writeback payload (also the MEM->EX forward).
//  Options  : MACC_MISALIGN_TRAP_EN - when defined, misaligned H/W accesses are
//             suppressed and flagged on o_misalign for one cycle.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module macc_stage #(
    parameter int BUS_AW = 32
) (
    input  logic              clk_sys,
    input  logic              rst_sys,
    input  logic              i_rd_wen,
    input  logic [4:0]        i_rd_addr,
    input  logic              i_mem_wreq,
    input  logic              i_mem_rreq,
    input  logic [BUS_AW-1:0] i_mem_addr,
    input  logic [31:0]       i_result,
    input  logic [31:0]       i_store_data,
    input  logic [2:0]        i_lsu_op,
    output logic              o_bus_req,
    output logic              o_bus_we,
    output logic [BUS_AW-1:0] o_bus_addr,
    output logic [3:0]        o_bus_be,
    output logic [31:0]       o_bus_wdata,
    input  logic              i_bus_gnt,
    input  logic              i_bus_rvalid,
    input  logic [31:0]       i_bus_rdata,
    output logic              o_stall,
    output logic              o_wb_rd_wen,
    output logic [4:0]        o_wb_rd_addr,
    output logic [31:0]       o_wb_data
`ifdef MACC_MISALIGN_TRAP_EN
    ,
    output logic              o_misalign
`endif
);

    localparam logic [0:0] c_IDLE   = 1'b0;
    localparam logic [0:0] c_WAIT_R = 1'b1;

    logic [0:0]  r_state;
    logic [0:0]  w_state_nxt;
    logic        w_mem_op;
    logic        w_misalign;
    logic [1:0]  w_off;
    logic [7:0]  w_rbyte;
    logic [15:0] w_rhalf;
    logic [31:0] w_load_data;

    assign w_mem_op   = i_mem_rreq | i_mem_wreq;
    assign w_off      = i_mem_addr[1:0];
    assign o_bus_we   = i_mem_wreq;
    assign o_bus_addr = {i_mem_addr[BUS_AW-1:2], 2'b00};

`ifdef MACC_MISALIGN_TRAP_EN
    // Halfword on an odd byte, or word off a word boundary, is misaligned.
    assign w_misalign = w_mem_op &
                        (((i_lsu_op[1:0] == 2'b01) && w_off[0]) ||
                         ((i_lsu_op[1:0] == 2'b10) && (w_off != 2'b00)));
`else
    // Without trapping, misaligned accesses are silently aligned down.
    assign w_misalign = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk_sys) begin
        if (rst_sys) r_state <= c_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Next-state: a granted load waits for its data; rvalid ends the wait.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:   if (w_mem_op && !i_mem_wreq && !w_misalign && i_bus_gnt)
                          w_state_nxt = c_WAIT_R;
            c_WAIT_R: if (i_bus_rvalid) w_state_nxt = c_IDLE;
            default:  w_state_nxt = c_IDLE;
        endcase
    end

    // Control outputs: request only from IDLE; stall until the access retires.
    always_comb begin
        o_bus_req = 1'b0;
        o_stall   = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_mem_op && !w_misalign) begin
                    o_bus_req = 1'b1;
                    // A granted store retires now; a load must wait for data.
                    o_stall   = i_mem_wreq ? !i_bus_gnt : 1'b1;
                end
            end
            c_WAIT_R: o_stall = !i_bus_rvalid;
            default:  o_stall = 1'b0;
        endcase
        if (rst_sys) o_bus_req = 1'b0;
    end

    // Lane steering for stores and lane selection/extension for loads.
    always_comb begin
        o_bus_be    = 4'b1111;
        o_bus_wdata = i_store_data;
        case (i_lsu_op[1:0])
            2'b00: begin
                o_bus_be    = 4'b0001 << w_off;
                o_bus_wdata = {4{i_store_data[7:0]}};
            end
            2'b01: begin
                o_bus_be    = w_off[1] ? 4'b1100 : 4'b0011;
                o_bus_wdata = {2{i_store_data[15:0]}};
            end
            default: ;
        endcase

        case (w_off)
            2'b00:   w_rbyte = i_bus_rdata[7:0];
            2'b01:   w_rbyte = i_bus_rdata[15:8];
            2'b10:   w_rbyte = i_bus_rdata[23:16];
            default: w_rbyte = i_bus_rdata[31:24];
        endcase
        w_rhalf = w_off[1] ? i_bus_rdata[31:16] : i_bus_rdata[15:0];

        case (i_lsu_op)
            3'b000:  w_load_data = {{24{w_rbyte[7]}}, w_rbyte};
            3'b001:  w_load_data = {{16{w_rhalf[15]}}, w_rhalf};
            3'b100:  w_load_data = {24'd0, w_rbyte};
            3'b101:  w_load_data = {16'd0, w_rhalf};
            default: w_load_data = i_bus_rdata;
        endcase
    end

    // Writeback register: bubble while stalled, load data on completion,
    // nothing for stores/trapped ops, ALU result otherwise.
    always_ff @(posedge clk_sys) begin
        if (rst_sys) begin
            o_wb_rd_wen  <= 1'b0;
            o_wb_rd_addr <= 5'd0;
            o_wb_data    <= 32'd0;
        end else if (o_stall) begin
            o_wb_rd_wen  <= 1'b0;
        end else if (r_state == c_WAIT_R) begin
            o_wb_rd_wen  <= i_rd_wen;
            o_wb_rd_addr <= i_rd_addr;
            o_wb_data    <= w_load_data;
        end else if (w_mem_op) begin
            o_wb_rd_wen  <= 1'b0;
        end else begin
            o_wb_rd_wen  <= i_rd_wen;
            o_wb_rd_addr <= i_rd_addr;
            o_wb_data    <= i_result;
        end
    end

`ifdef MACC_MISALIGN_TRAP_EN
    // One-cycle flag after a misaligned access retires from IDLE.
    always_ff @(posedge clk_sys) begin
        if (rst_sys) o_misalign <= 1'b0;
        else         o_misalign <= w_misalign && (r_state == c_IDLE);
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_macc_stage.sv
// ============================================================================
//  Module   : tb_macc_stage
//  Purpose  : Scoreboard bench for macc_stage. Expected writebacks are queued
//             at issue; a monitor pops and compares on every o_wb_rd_wen.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_macc_stage;

    logic        clk_sys = 1'b0;
    logic        rst_sys;
    logic        i_rd_wen;
    logic [4:0]  i_rd_addr;
    logic        i_mem_wreq;
    logic        i_mem_rreq;
    logic [31:0] i_mem_addr;
    logic [31:0] i_result;
    logic [31:0] i_store_data;
    logic [2:0]  i_lsu_op;
    logic        o_bus_req;
    logic        o_bus_we;
    logic [31:0] o_bus_addr;
    logic [3:0]  o_bus_be;
    logic [31:0] o_bus_wdata;
    logic        i_bus_gnt;
    logic        i_bus_rvalid;
    logic [31:0] i_bus_rdata;
    logic        o_stall;
    logic        o_wb_rd_wen;
    logic [4:0]  o_wb_rd_addr;
    logic [31:0] o_wb_data;

    int vectors     = 0;
    int miscompares = 0;
    logic [36:0] exp_q[$];   // {rd, data}

    macc_stage #(.BUS_AW(32)) dut (
        .clk_sys(clk_sys), .rst_sys(rst_sys),
        .i_rd_wen(i_rd_wen), .i_rd_addr(i_rd_addr),
        .i_mem_wreq(i_mem_wreq), .i_mem_rreq(i_mem_rreq),
        .i_mem_addr(i_mem_addr), .i_result(i_result),
        .i_store_data(i_store_data), .i_lsu_op(i_lsu_op),
        .o_bus_req(o_bus_req), .o_bus_we(o_bus_we),
        .o_bus_addr(o_bus_addr), .o_bus_be(o_bus_be),
        .o_bus_wdata(o_bus_wdata), .i_bus_gnt(i_bus_gnt),
        .i_bus_rvalid(i_bus_rvalid), .i_bus_rdata(i_bus_rdata),
        .o_stall(o_stall), .o_wb_rd_wen(o_wb_rd_wen),
        .o_wb_rd_addr(o_wb_rd_addr), .o_wb_data(o_wb_data)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every writeback must match the oldest queued expectation.
    always @(negedge clk_sys) begin
        if (!rst_sys && o_wb_rd_wen === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_wb", {27'd0, o_wb_rd_addr}, 32'hFFFF_FFFF);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                check("wb_rd",   {27'd0, o_wb_rd_addr}, {27'd0, e[36:32]});
                check("wb_data", o_wb_data, e[31:0]);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic idle();
        i_rd_wen = 1'b0; i_rd_addr = 5'd0; i_mem_wreq = 1'b0; i_mem_rreq = 1'b0;
        i_mem_addr = 32'd0; i_result = 32'd0; i_store_data = 32'd0; i_lsu_op = 3'd0;
        i_bus_gnt = 1'b0; i_bus_rvalid = 1'b0; i_bus_rdata = 32'd0;
    endtask

    task automatic alu(input logic wen, input logic [4:0] rd, input logic [31:0] res);
        idle();
        i_rd_wen = wen; i_rd_addr = rd; i_result = res;
        if (wen) exp_q.push_back({rd, res});
        @(negedge clk_sys);
        check("alu_stall", {31'd0, o_stall}, 32'd0);
        check("alu_req",   {31'd0, o_bus_req}, 32'd0);
        next_cycle();
    endtask

    task automatic do_store(input logic both, input logic [31:0] addr, input logic [2:0] op,
                            input logic [31:0] sdata, input int gnt_delay,
                            input logic [3:0] ebe, input logic [31:0] ewd);
        idle();
        i_mem_wreq = 1'b1; i_mem_rreq = both; i_mem_addr = addr; i_lsu_op = op;
        i_store_data = sdata; i_rd_wen = 1'b1; i_rd_addr = 5'd9;
        for (int i = 0; i < gnt_delay; i++) begin
            @(negedge clk_sys);
            check("st_wait_req",   {31'd0, o_bus_req}, 32'd1);
            check("st_wait_stall", {31'd0, o_stall}, 32'd1);
            next_cycle();
        end
        i_bus_gnt = 1'b1;
        @(negedge clk_sys);
        check("st_req",   {31'd0, o_bus_req}, 32'd1);
        check("st_we",    {31'd0, o_bus_we}, 32'd1);
        check("st_addr",  o_bus_addr, {addr[31:2], 2'b00});
        check("st_be",    {28'd0, o_bus_be}, {28'd0, ebe});
        check("st_wdata", o_bus_wdata, ewd);
        check("st_stall", {31'd0, o_stall}, 32'd0);
        next_cycle();
        idle();
    endtask

    task automatic do_load(input logic [31:0] addr, input logic [2:0] op, input logic [4:0] rd,
                           input logic [31:0] rdata, input int lat,
                           input logic [3:0] ebe, input logic [31:0] edata);
        idle();
        i_mem_rreq = 1'b1; i_mem_addr = addr; i_lsu_op = op;
        i_rd_wen = 1'b1; i_rd_addr = rd; i_bus_gnt = 1'b1;
        exp_q.push_back({rd, edata});
        @(negedge clk_sys);
        check("ld_req",   {31'd0, o_bus_req}, 32'd1);
        check("ld_we",    {31'd0, o_bus_we}, 32'd0);
        check("ld_addr",  o_bus_addr, {addr[31:2], 2'b00});
        check("ld_be",    {28'd0, o_bus_be}, {28'd0, ebe});
        check("ld_stall", {31'd0, o_stall}, 32'd1);
        next_cycle();
        i_bus_gnt = 1'b0;
        for (int i = 1; i < lat; i++) begin
            @(negedge clk_sys);
            check("ldw_req",   {31'd0, o_bus_req}, 32'd0);
            check("ldw_stall", {31'd0, o_stall}, 32'd1);
            next_cycle();
        end
        i_bus_rvalid = 1'b1; i_bus_rdata = rdata;
        @(negedge clk_sys);
        check("ld_done_stall", {31'd0, o_stall}, 32'd0);
        next_cycle();
        idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        rst_sys = 1'b1;
        i_mem_rreq = 1'b1;                     // request must be masked in reset
        next_cycle(); next_cycle();
        @(negedge clk_sys);
        check("rst_wen",  {31'd0, o_wb_rd_wen}, 32'd0);
        check("rst_rd",   {27'd0, o_wb_rd_addr}, 32'd0);
        check("rst_data", o_wb_data, 32'd0);
        check("rst_req",  {31'd0, o_bus_req}, 32'd0);
        next_cycle();
        rst_sys = 1'b0;
        idle();

        alu(1'b1, 5'd5,  32'h0000_1234);
        alu(1'b0, 5'd7,  32'h1111_1111);
        alu(1'b1, 5'd31, 32'hDEAD_BEEF);

        do_store(1'b0, 32'h0000_1003, 3'b000, 32'h1234_56AB, 2, 4'b1000, 32'hABAB_ABAB);
        do_store(1'b0, 32'h0000_1002, 3'b001, 32'h0000_BEEF, 0, 4'b1100, 32'hBEEF_BEEF);
        do_store(1'b1, 32'h0000_1004, 3'b010, 32'h1234_5678, 0, 4'b1111, 32'h1234_5678);

        do_load(32'h0000_2002, 3'b000, 5'd10, 32'h0080_0000, 3, 4'b0100, 32'hFFFF_FF80);
        do_load(32'h0000_2002, 3'b100, 5'd11, 32'h0080_0000, 3, 4'b0100, 32'h0000_0080);
        do_load(32'h0000_2002, 3'b001, 5'd12, 32'h8001_0000, 1, 4'b1100, 32'hFFFF_8001);
        do_load(32'h0000_2000, 3'b101, 5'd13, 32'h8001_7FFF, 1, 4'b0011, 32'h0000_7FFF);
        do_load(32'h0000_2000, 3'b001, 5'd14, 32'h0000_8000, 2, 4'b0011, 32'hFFFF_8000);
        do_load(32'h0000_2004, 3'b010, 5'd15, 32'hCAFE_F00D, 1, 4'b1111, 32'hCAFE_F00D);
        do_load(32'h0000_2001, 3'b000, 5'd16, 32'h0000_7F00, 1, 4'b0010, 32'h0000_007F);
        do_load(32'h0000_2003, 3'b001, 5'd17, 32'h7FFF_0000, 1, 4'b1100, 32'h0000_7FFF);
        alu(1'b1, 5'd1, 32'h0000_0042);        // forwarding source after a load

        // Reset while waiting for read data; the late rvalid must be ignored.
        idle();
        i_mem_rreq = 1'b1; i_mem_addr = 32'h0000_2008; i_lsu_op = 3'b010;
        i_rd_wen = 1'b1; i_rd_addr = 5'd20; i_bus_gnt = 1'b1;
        next_cycle();
        i_bus_gnt = 1'b0;
        rst_sys = 1'b1;
        @(negedge clk_sys);
        check("rst_wait_req", {31'd0, o_bus_req}, 32'd0);
        next_cycle();
        rst_sys = 1'b0;
        idle();
        i_rd_wen = 1'b1; i_rd_addr = 5'd3; i_result = 32'h0000_0055;
        i_bus_rvalid = 1'b1; i_bus_rdata = 32'h9999_9999;
        exp_q.push_back({5'd3, 32'h0000_0055});
        @(negedge clk_sys);
        check("late_rvalid_stall", {31'd0, o_stall}, 32'd0);
        check("late_rvalid_req",   {31'd0, o_bus_req}, 32'd0);
        next_cycle();
        idle();

        next_cycle(); next_cycle();
        check("queue_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
